iram_loader: RTL and testbench
==============================

# iram_loader

Monitor-side loader for the instruction RAM. It turns a byte stream into word writes on the IRAM write port, reads words back over the shared IRAM read port, and issues the start pulse and start address that launch the fetch stage. It sits between the monitor/UART command logic and the fetch stage's `i_ram_*`, `i_read_sel`, `cpu_start` and `start_adr` inputs.

## Interface
**Parameters**
- `IWIDTH`, default 12 — IRAM word-address width; the RAM holds 2^IWIDTH words.

**Ports** (name, direction, width, meaning)
- `clk` in 1 — clock.
- `rst_n` in 1 — reset; asynchronous, active-low.
- `cmd_valid` in 1 — command present.
- `cmd_ready` out 1 — command accepted when `cmd_valid & cmd_ready`.
- `cmd_op` in 2 — 00 = write burst, 01 = read burst, 10 = start, 11 = ignored (accepted, no action).
- `cmd_adr` in IWIDTH — first word address, bits [IWIDTH+1:2].
- `cmd_len` in IWIDTH+1 — word count; 0 means no words.
- `cmd_start_adr` in 30 — CPU start address, bits [31:2].
- `rx_valid` in 1 — write-data byte valid.
- `rx_data` in 8 — write-data byte.
- `rx_ready` out 1 — write-data byte accepted.
- `tx_valid` out 1 — read-data byte valid.
- `tx_data` out 8 — read-data byte.
- `tx_ready` in 1 — read-data byte taken.
- `i_ram_wadr` out IWIDTH — IRAM write address.
- `i_ram_wdata` out 32 — IRAM write data.
- `i_ram_wen` out 1 — IRAM write strobe.
- `i_ram_radr` out IWIDTH — IRAM read address.
- `i_ram_rdata` in 32 — IRAM read data; synchronous, valid the cycle after the address is presented.
- `i_read_sel` out 1 — steals the IRAM read port from fetch.
- `cpu_start` out 1 — one-cycle start pulse.
- `start_adr` out 30 — start address, registered.
- `busy` out 1 — block is not in IDLE.

## Operation
- **States:** IDLE, WR_BYTE, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND, START.
- **IDLE:** `cmd_ready` = 1 only here.
  - On accept, latch `adr` = `cmd_adr`, `cnt` = `cmd_len`, `bsel` = 0.
  - op 00 goes to WR_BYTE; op 01 goes to RD_ADDR; op 10 goes to START; op 11 stays in IDLE.
  - If `cnt` = 0 on op 00 or 01, return to IDLE with no RAM access.
- **WR_BYTE:** `rx_ready` = 1.
  - Each accepted byte goes into `wbuf[8*bsel+7:8*bsel]` (little-endian), then `bsel` increments.
  - On the byte with `bsel` = 3, go to WR_COMMIT.
- **WR_COMMIT:** `rx_ready` = 0.
  - `i_ram_wen` = 1 for exactly one cycle, with `i_ram_wadr` = `adr` and `i_ram_wdata` = `wbuf`.
  - Then `adr` += 1, `cnt` -= 1, `bsel` = 0.
  - Next state: IDLE if `cnt` was 1, else WR_BYTE.
- **RD_ADDR:** `i_ram_radr` = `adr`; go to RD_WAIT.
- **RD_WAIT:** capture `rbuf` = `i_ram_rdata`; go to RD_SEND with `bsel` = 0.
- **RD_SEND:** `tx_valid` = 1, `tx_data` = `rbuf[8*bsel+7:8*bsel]`.
  - On `tx_ready`, `bsel` increments.
  - After byte 3 is taken, `adr` += 1 and `cnt` -= 1; next state is IDLE if `cnt` was 1, else RD_ADDR.
- **`i_read_sel`:** 1 in RD_ADDR, RD_WAIT and RD_SEND, and 0 everywhere else.
- **START:** `start_adr` <= `cmd_start_adr`; `cpu_start` = 1 for one cycle; go to IDLE.
- **Address arithmetic:** `adr` is IWIDTH bits and wraps modulo 2^IWIDTH (last word goes to word 0). `cnt` never underflows.
- **Usage rule:** burst and start commands are issued only while the CPU is halted. The block does not check this.
- **Reset mid-operation:** return to IDLE.
  - A partially assembled word is discarded and not written.
  - No `i_ram_wen` or `cpu_start` is emitted on reset exit.
- **Reset values:** `i_ram_wen`, `i_read_sel`, `cpu_start`, `tx_valid`, `rx_ready`, `busy` = 0; `cmd_ready` = 1; `i_ram_wadr`, `i_ram_radr`, `i_ram_wdata`, `tx_data` = 0; `start_adr` = 0.

## Timing
- Command accept to first `rx_ready`: 1 cycle.
- Fourth byte accepted in cycle N: `i_ram_wen` is high in cycle N+1, and `rx_ready` is high again in N+2.
- Peak write rate: one word per 5 cycles.
- Read: address presented in cycle M (RD_ADDR), `rbuf` captured in M+1, first `tx_valid` in M+2.
  - With `tx_ready` held high, one word per 6 cycles.
- `tx_valid`/`tx_data` stay stable until `tx_ready`; there is no combinational path from `tx_ready` to `tx_valid`.
- Start command accepted in cycle K: `cpu_start` is high in K+1, `start_adr` is updated at the end of K+1, and `cmd_ready` = 1 in K+2.
- `busy` is high from the cycle after accept until the state returns to IDLE.
- All outputs are registered or decoded from state only; there is no input-to-output combinational path.

## Test plan
- **Write one word:** op 00, adr 0x010, len 1, bytes 13 05 00 00. Expect exactly one `i_ram_wen` with wadr 0x010, wdata 0x0000_0513, then `cmd_ready` = 1.
- **Write then read, wrap-around:** write len 3 at adr 0xFFF (IWIDTH 12) with words A, B, C; then read len 3 at 0xFFF. Expect writes at 0xFFF, 0x000, 0x001, and tx bytes returning A, B, C little-endian in order.
- **TX backpressure:** read len 1 with `tx_ready` low for 10 cycles per byte. Expect `tx_data` stable while waiting, 4 bytes out, `i_read_sel` high throughout and low afterwards.
- **Zero length:** op 00 with len 0 and op 01 with len 0. Expect no `i_ram_wen`, no `tx_valid`, and `cmd_ready` back high within 1 cycle.
- **Start:** op 10, start_adr 0x0000_0040 (i.e. `cmd_start_adr` = 0x10). Expect a single-cycle `cpu_start` and `start_adr` = 0x10.
- **Reset mid-burst:** assert `rst_n` low after 2 of 4 bytes. Expect no write, all outputs at reset values, and the next command processed normally.

Source files
------------

// File: rtl/iram_loader.sv
// Monitor-side IRAM loader: assembles byte streams into IRAM word writes, streams words
// back out as bytes over the shared read port, and launches the fetch stage.
module iram_loader #(
   parameter int IWIDTH = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [IWIDTH-1:0] cmd_adr,
   input  logic [IWIDTH:0]   cmd_len,
   input  logic [29:0]       cmd_start_adr,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              tx_valid,
   output logic [7:0]        tx_data,
   input  logic              tx_ready,
   output logic [IWIDTH-1:0] i_ram_wadr,
   output logic [31:0]       i_ram_wdata,
   output logic              i_ram_wen,
   output logic [IWIDTH-1:0] i_ram_radr,
   input  logic [31:0]       i_ram_rdata,
   output logic              i_read_sel,
   output logic              cpu_start,
   output logic [29:0]       start_adr,
   output logic              busy
);

   typedef enum logic [2:0] {
      IDLE, WR_BYTE, WR_COMMIT, RD_ADDR, RD_WAIT, RD_SEND, START
   } state_t;

   localparam logic [IWIDTH-1:0] ADR_ONE = 1;
   localparam logic [IWIDTH:0]   CNT_ONE = 1;
   localparam logic [IWIDTH:0]   CNT_ZERO = '0;

   state_t            state;
   logic [IWIDTH-1:0] adr;
   logic [IWIDTH:0]   cnt;
   logic [1:0]        bsel;
   logic [31:0]       wbuf;
   logic [31:0]       rbuf;
   logic [29:0]       sadr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         adr       <= '0;
         cnt       <= '0;
         bsel      <= '0;
         wbuf      <= '0;
         rbuf      <= '0;
         sadr      <= '0;
         start_adr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  adr  <= cmd_adr;
                  cnt  <= cmd_len;
                  bsel <= 2'd0;
                  sadr <= cmd_start_adr;
                  case (cmd_op)
                     2'b00:   if (cmd_len != CNT_ZERO) state <= WR_BYTE;
                     2'b01:   if (cmd_len != CNT_ZERO) state <= RD_ADDR;
                     2'b10:   state <= START;
                     default: state <= IDLE;
                  endcase
               end
            end
            WR_BYTE: begin
               if (rx_valid) begin
                  wbuf[{bsel, 3'b000} +: 8] <= rx_data;
                  bsel <= bsel + 2'd1;
                  if (bsel == 2'd3) state <= WR_COMMIT;
               end
            end
            WR_COMMIT: begin
               adr  <= adr + ADR_ONE;
               bsel <= 2'd0;
               if (cnt != CNT_ZERO) cnt <= cnt - CNT_ONE;
               state <= (cnt <= CNT_ONE) ? IDLE : WR_BYTE;
            end
            RD_ADDR: state <= RD_WAIT;
            RD_WAIT: begin
               rbuf  <= i_ram_rdata;
               bsel  <= 2'd0;
               state <= RD_SEND;
            end
            RD_SEND: begin
               if (tx_ready) begin
                  bsel <= bsel + 2'd1;
                  if (bsel == 2'd3) begin
                     adr <= adr + ADR_ONE;
                     if (cnt != CNT_ZERO) cnt <= cnt - CNT_ONE;
                     state <= (cnt <= CNT_ONE) ? IDLE : RD_ADDR;
                  end
               end
            end
            START: begin
               start_adr <= sadr;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Every output is a decode of registered state, so no input reaches an output combinationally.
   assign cmd_ready   = (state == IDLE);
   assign busy        = (state != IDLE);
   assign rx_ready    = (state == WR_BYTE);
   assign i_ram_wen   = (state == WR_COMMIT);
   assign i_ram_wadr  = adr;
   assign i_ram_wdata = wbuf;
   assign i_ram_radr  = adr;
   assign i_read_sel  = (state == RD_ADDR) || (state == RD_WAIT) || (state == RD_SEND);
   assign tx_valid    = (state == RD_SEND);
   assign tx_data     = rbuf[{bsel, 3'b000} +: 8];
   assign cpu_start   = (state == START);

endmodule

// File: tb/tb_iram_loader.sv
// Directed bench for iram_loader with a behavioural synchronous IRAM model.
module tb_iram_loader;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b11;
   logic [11:0] cmd_adr = '0;
   logic [12:0] cmd_len = '0;
   logic [29:0] cmd_start_adr = '0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = '0;
   logic        rx_ready;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready = 1'b0;
   logic [11:0] i_ram_wadr;
   logic [31:0] i_ram_wdata;
   logic        i_ram_wen;
   logic [11:0] i_ram_radr;
   logic [31:0] i_ram_rdata = '0;
   logic        i_read_sel;
   logic        cpu_start;
   logic [29:0] start_adr;
   logic        busy;

   int n_checks = 0;
   int n_pass   = 0;

   logic [31:0] mem [0:4095];
   logic [11:0] wlog [0:63];
   int wen_cnt   = 0;
   int txv_cnt   = 0;
   int start_cnt = 0;

   iram_loader #(.IWIDTH(12)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
      .cmd_adr(cmd_adr), .cmd_len(cmd_len), .cmd_start_adr(cmd_start_adr),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
      .i_ram_wadr(i_ram_wadr), .i_ram_wdata(i_ram_wdata), .i_ram_wen(i_ram_wen),
      .i_ram_radr(i_ram_radr), .i_ram_rdata(i_ram_rdata), .i_read_sel(i_read_sel),
      .cpu_start(cpu_start), .start_adr(start_adr), .busy(busy)
   );

   always #5 clk = ~clk;

   // IRAM model plus event counters
   always @(posedge clk) begin
      i_ram_rdata <= mem[i_ram_radr];
      if (i_ram_wen) begin
         mem[i_ram_wadr] <= i_ram_wdata;
         wlog[wen_cnt[5:0]] <= i_ram_wadr;
         wen_cnt <= wen_cnt + 1;
      end
      if (tx_valid)  txv_cnt   <= txv_cnt + 1;
      if (cpu_start) start_cnt <= start_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [11:0] adr,
                           input logic [12:0] len, input logic [29:0] sadr);
      @(negedge clk);
      cmd_op = op; cmd_adr = adr; cmd_len = len; cmd_start_adr = sadr;
      cmd_valid = 1'b1;
      for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) check("cmd_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      $display("cmd op=%0d adr=0x%03h len=%0d sadr=0x%0h", op, adr, len, sadr);
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(negedge clk);
      rx_valid = 1'b1; rx_data = b;
      for (int i = 0; i < 100 && !rx_ready; i++) @(negedge clk);
      if (!rx_ready) check("rx_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1 rx_valid = 1'b0;
      $display("rx byte 0x%02h", b);
   endtask

   task automatic recv_byte(input logic [7:0] exp, input int dly);
      logic [7:0] b;
      @(negedge clk);
      for (int i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
      if (!tx_valid) check("tx_timeout", 32'd0, 32'd1);
      b = tx_data;
      for (int i = 0; i < dly; i++) begin
         @(negedge clk);
         check("tx_stable", {24'd0, tx_data}, {24'd0, b});
         check("rd_sel_wait", {31'd0, i_read_sel}, 32'd1);
      end
      tx_ready = 1'b1;
      @(posedge clk);
      #1 tx_ready = 1'b0;
      check("tx_byte", {24'd0, b}, {24'd0, exp});
      $display("tx byte 0x%02h (expected 0x%02h)", b, exp);
   endtask

   task automatic wait_idle();
      @(negedge clk);
      for (int i = 0; i < 100 && !cmd_ready; i++) @(negedge clk);
      if (!cmd_ready) check("idle_timeout", 32'd0, 32'd1);
   endtask

   logic [7:0] wr_bytes [0:11] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h88, 8'h77, 8'h66, 8'h55,
                                   8'hCC, 8'hBB, 8'hAA, 8'h99};
   int base;
   int txv0;

   initial begin
      // reset state
      #12;
      check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_start_adr", {2'd0, start_adr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single word write
      base = wen_cnt;
      send_cmd(2'b00, 12'h010, 13'd1, 30'd0);
      check("busy_wr", {31'd0, busy}, 32'd1);
      send_byte(8'h13); send_byte(8'h05); send_byte(8'h00); send_byte(8'h00);
      @(negedge clk);
      check("wen_n1", {31'd0, i_ram_wen}, 32'd1);
      check("wadr_n1", {20'd0, i_ram_wadr}, 32'h010);
      check("wdata_n1", i_ram_wdata, 32'h0000_0513);
      @(negedge clk);
      check("wen_n2", {31'd0, i_ram_wen}, 32'd0);
      check("cmd_ready_after_wr", {31'd0, cmd_ready}, 32'd1);
      check("wen_count_1", wen_cnt - base, 32'd1);

      // wrap-around write then read-back
      base = wen_cnt;
      send_cmd(2'b00, 12'hFFF, 13'd3, 30'd0);
      for (int i = 0; i < 12; i++) send_byte(wr_bytes[i]);
      wait_idle();
      check("wen_count_3", wen_cnt - base, 32'd3);
      check("wrap_adr0", {20'd0, wlog[base[5:0]]}, 32'hFFF);
      check("wrap_adr1", {20'd0, wlog[base[5:0] + 6'd1]}, 32'h000);
      check("wrap_adr2", {20'd0, wlog[base[5:0] + 6'd2]}, 32'h001);
      send_cmd(2'b01, 12'hFFF, 13'd3, 30'd0);
      check("rd_sel_read", {31'd0, i_read_sel}, 32'd1);
      for (int i = 0; i < 12; i++) recv_byte(wr_bytes[i], 0);
      wait_idle();
      check("rd_sel_after", {31'd0, i_read_sel}, 32'd0);

      // backpressure on the read path
      send_cmd(2'b01, 12'h010, 13'd1, 30'd0);
      recv_byte(8'h13, 10); recv_byte(8'h05, 10); recv_byte(8'h00, 10); recv_byte(8'h00, 10);
      @(negedge clk);
      check("rd_sel_bp_after", {31'd0, i_read_sel}, 32'd0);
      check("tx_valid_bp_after", {31'd0, tx_valid}, 32'd0);

      // zero-length bursts
      base = wen_cnt; txv0 = txv_cnt;
      send_cmd(2'b00, 12'h005, 13'd0, 30'd0);
      @(negedge clk);
      check("zlen_wr_ready", {31'd0, cmd_ready}, 32'd1);
      send_cmd(2'b01, 12'h005, 13'd0, 30'd0);
      @(negedge clk);
      check("zlen_rd_ready", {31'd0, cmd_ready}, 32'd1);
      check("zlen_no_wen", wen_cnt - base, 32'd0);
      check("zlen_no_tx", txv_cnt - txv0, 32'd0);

      // start pulse
      base = start_cnt;
      send_cmd(2'b10, 12'h000, 13'd0, 30'h10);
      @(negedge clk);
      check("cpu_start_k1", {31'd0, cpu_start}, 32'd1);
      @(negedge clk);
      check("cpu_start_k2", {31'd0, cpu_start}, 32'd0);
      check("start_adr", {2'd0, start_adr}, 32'h10);
      check("cmd_ready_k2", {31'd0, cmd_ready}, 32'd1);
      check("start_count", start_cnt - base, 32'd1);

      // reset in the middle of a write burst
      base = wen_cnt;
      send_cmd(2'b00, 12'h020, 13'd1, 30'd0);
      send_byte(8'h5A); send_byte(8'hA5);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mr_wen", {31'd0, i_ram_wen}, 32'd0);
      check("mr_rd_sel", {31'd0, i_read_sel}, 32'd0);
      check("mr_cpu_start", {31'd0, cpu_start}, 32'd0);
      check("mr_tx_valid", {31'd0, tx_valid}, 32'd0);
      check("mr_rx_ready", {31'd0, rx_ready}, 32'd0);
      check("mr_busy", {31'd0, busy}, 32'd0);
      check("mr_cmd_ready", {31'd0, cmd_ready}, 32'd1);
      check("mr_wadr", {20'd0, i_ram_wadr}, 32'd0);
      check("mr_radr", {20'd0, i_ram_radr}, 32'd0);
      check("mr_wdata", i_ram_wdata, 32'd0);
      check("mr_tx_data", {24'd0, tx_data}, 32'd0);
      check("mr_start_adr", {2'd0, start_adr}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("mr_no_write", wen_cnt - base, 32'd0);
      check("mr_no_start", {31'd0, cpu_start}, 32'd0);

      // next command after reset
      send_cmd(2'b00, 12'h020, 13'd1, 30'd0);
      send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC); send_byte(8'hDD);
      wait_idle();
      check("post_rst_wen", wen_cnt - base, 32'd1);
      check("post_rst_mem", mem[12'h020], 32'hDDCC_BBAA);
      send_cmd(2'b01, 12'h020, 13'd1, 30'd0);
      recv_byte(8'hAA, 0); recv_byte(8'hBB, 0); recv_byte(8'hCC, 0); recv_byte(8'hDD, 0);
      wait_idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
